instruction_assembly_register: RTL and testbench
================================================

INSTRUCTION_ASSEMBLY_REGISTER -- requirements
Module: instruction_assembly_register

Interface
REQ-001 SHALL have parameter BUS_W, default 8, input byte-bus width in bits.
REQ-002 SHALL have parameter INSTR_BYTES, default 2, bus beats per instruction word (legal range 1..8).
REQ-003 SHALL have parameter HIGH_FIRST, default 1; 1 = first beat fills the top lane, 0 = first beat fills lane 0.
REQ-004 SHALL have port Clock, input, 1, single clock; all state changes on rising edge.
REQ-005 SHALL have port Reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port Write, input, 1, a beat is present on I this cycle.
REQ-007 SHALL have port I, input, BUS_W, instruction beat data.
REQ-008 SHALL have port Take, input, 1, consumer accepts the current IROut.
REQ-009 SHALL have port Flush, input, 1, synchronous abort of assembly and of the valid word.
REQ-010 SHALL have port WriteReady, output, 1, a beat offered this cycle will be accepted.
REQ-011 SHALL have port IROut, output, BUS_W*INSTR_BYTES, assembled instruction word.
REQ-012 SHALL have port IRValid, output, 1, IROut holds an untaken instruction.
REQ-013 SHALL have port ByteCount, output, CNT_W = max(1,clog2(INSTR_BYTES)), beats collected toward the next word.
REQ-014 SHALL have port Overrun, output, 1, sticky: a beat was offered while WriteReady=0.

Function
REQ-015 SHALL accept a beat when Write=1 and WriteReady=1 and Flush=0, storing it in the lane selected by ByteCount and HIGH_FIRST (HIGH_FIRST=1: lane INSTR_BYTES-1-ByteCount).
REQ-016 SHALL increment ByteCount per accepted beat, wrapping to 0 on the beat where ByteCount=INSTR_BYTES-1 (completing beat).
REQ-017 SHALL, on the completing-beat edge, load IROut with the full word (completing beat included) and set IRValid; latency 1 cycle from the completing beat.
REQ-018 SHALL treat INSTR_BYTES=1 as every accepted beat being a completing beat; ByteCount stays 0.
REQ-019 SHALL clear IRValid on the edge where IRValid=1 and Take=1, unless a completing beat is accepted on that same edge, in which case IROut takes the new word and IRValid stays 1.
REQ-020 SHALL ignore Take while IRValid=0.
REQ-021 SHALL hold IROut unchanged except on a completing beat or Reset; Take and Flush do not alter IROut.
REQ-022 SHALL, on an offered beat with WriteReady=0, drop the beat, leave all lanes and ByteCount unchanged, and set Overrun.
REQ-023 SHALL give Flush priority over Write and Take: ByteCount<=0, IRValid<=0, Overrun<=0, offered beat discarded, partial lanes discarded.

Reset
REQ-024 SHALL, while Reset=1, force IROut=0, IRValid=0, ByteCount=0, Overrun=0 and assembly lanes=0, independent of Clock.
REQ-025 SHALL abandon any partial word on Reset; first accepted beat after release is beat 0.

Configuration
REQ-026 SHALL, with IR_PREFETCH_EN defined, keep a separate assembly buffer so beats of the next word are accepted while IRValid=1: WriteReady = !IRValid | (ByteCount != INSTR_BYTES-1) | Take.
REQ-027 SHALL, without IR_PREFETCH_EN, drive WriteReady = !IRValid (no next-word beats until taken); lanes may then be assembled in IROut's shadow directly.

Structure
REQ-028 SHALL place default parameter values, the CNT_W width function and the lane-index helper in shared package ir_pkg.
REQ-029 SHALL implement lane storage and ByteCount in sub-module ir_beat_assembler; top level holds IROut/IRValid/Overrun and handshake logic.

Verification (BUS_W=8, INSTR_BYTES=2 unless stated)
REQ-030 SHALL check: HIGH_FIRST=1, beats 0x12,0x34 -> IROut=0x1234, IRValid=1 one cycle after second beat; HIGH_FIRST=0 same beats -> 0x3412.
REQ-031 SHALL check: beat 0xAB, Reset pulsed mid-cycle -> IROut=0, ByteCount=0; then 0x56,0x78 -> IROut=0x5678.
REQ-032 SHALL check without IR_PREFETCH_EN: IRValid=1, Take=0, Write 0x9A -> WriteReady=0, Overrun=1, IROut unchanged.
REQ-033 SHALL check with IR_PREFETCH_EN: IROut=0x1234 valid, beat 0x56 accepted (ByteCount=1); 0x78 with Take=0 refused; 0x78 with Take=1 -> IROut=0x5678, IRValid stays 1.
REQ-034 SHALL check: Flush with Write=1,I=0xCD while ByteCount=1 and IRValid=1 -> ByteCount=0, IRValid=0, Overrun=0, IROut retained.
REQ-035 SHALL check INSTR_BYTES=3, BUS_W=4, HIGH_FIRST=1: beats 0xA,0xB,0xC -> IROut=0xABC, ByteCount sequence 0,1,2,0.

Source files
------------

// File: rtl/ir_pkg.sv
// Shared defaults and helpers for the instruction assembly register:
// counter width and beat-to-lane mapping.
package ir_pkg;

  localparam int DEF_BUS_W       = 8;
  localparam int DEF_INSTR_BYTES = 2;
  localparam int DEF_HIGH_FIRST  = 1;

  // A one-beat word still gets a 1-bit counter so ByteCount is never zero-width.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned lane_idx(input int unsigned cnt, input int unsigned n,
                                           input int hf);
    return (hf != 0) ? (n - 1 - cnt) : cnt;
  endfunction

endpackage

// File: rtl/ir_beat_assembler.sv
// Lane storage and beat counter: collects accepted beats into lanes and
// presents the merged word (incoming beat included) for the completing edge.
module ir_beat_assembler import ir_pkg::*; #(
  parameter  int BUS_W       = DEF_BUS_W,
  parameter  int INSTR_BYTES = DEF_INSTR_BYTES,
  parameter  int HIGH_FIRST  = DEF_HIGH_FIRST,
  localparam int CNT_W       = cnt_w(INSTR_BYTES),
  localparam int WORD_W      = BUS_W * INSTR_BYTES
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              accept_i,
  input  logic              flush_i,
  input  logic [BUS_W-1:0]  beat_i,
  output logic [CNT_W-1:0]  count_o,
  output logic              complete_o,
  output logic [WORD_W-1:0] word_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(INSTR_BYTES - 1);
  localparam int unsigned      NB   = INSTR_BYTES;

  logic [INSTR_BYTES-1:0][BUS_W-1:0] lanes_q, lanes_d, merged;
  logic [CNT_W-1:0]                  count_q, count_d;
  logic                              complete;

  assign complete = accept_i && (count_q == LAST);

  always_comb begin
    merged = lanes_q;
    for (int unsigned l = 0; l < NB; l++) begin
      if (accept_i && (lane_idx(32'(count_q), NB, HIGH_FIRST) == l)) begin
        merged[l] = beat_i;
      end
    end
  end

  // Lanes restart clean after a completed word or flush so no stale beats leak.
  always_comb begin
    count_d = count_q;
    lanes_d = merged;
    if (flush_i || complete) begin
      count_d = '0;
      lanes_d = '0;
    end else if (accept_i) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
      lanes_q <= '0;
    end else begin
      count_q <= count_d;
      lanes_q <= lanes_d;
    end
  end

  assign count_o    = count_q;
  assign complete_o = complete;
  assign word_o     = merged;

endmodule

// File: rtl/instruction_assembly_register.sv
// Instruction assembly register: builds INSTR_BYTES bus beats into one word.
// Define IR_PREFETCH_EN to accept next-word beats while a word is still valid.
module instruction_assembly_register import ir_pkg::*; #(
  parameter  int BUS_W       = DEF_BUS_W,
  parameter  int INSTR_BYTES = DEF_INSTR_BYTES,
  parameter  int HIGH_FIRST  = DEF_HIGH_FIRST,
  localparam int CNT_W       = cnt_w(INSTR_BYTES)
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic                         Write,
  input  logic [BUS_W-1:0]             I,
  input  logic                         Take,
  input  logic                         Flush,
  output logic                         WriteReady,
  output logic [BUS_W*INSTR_BYTES-1:0] IROut,
  output logic                         IRValid,
  output logic [CNT_W-1:0]             ByteCount,
  output logic                         Overrun
);

  localparam int               WORD_W = BUS_W * INSTR_BYTES;
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(INSTR_BYTES - 1);

  logic [WORD_W-1:0] irout_q, irout_d, word;
  logic              irvalid_q, irvalid_d;
  logic              overrun_q, overrun_d;
  logic [CNT_W-1:0]  count;
  logic              accept, complete, ready;

`ifdef IR_PREFETCH_EN
  // Only the completing beat must wait for the held word to be taken.
  assign ready = !irvalid_q || (count != LAST) || Take;
`else
  assign ready = !irvalid_q;
`endif

  assign accept = Write && ready && !Flush;

  ir_beat_assembler #(
    .BUS_W       (BUS_W),
    .INSTR_BYTES (INSTR_BYTES),
    .HIGH_FIRST  (HIGH_FIRST)
  ) u_asm (
    .clk_i      (Clock),
    .rst_i      (Reset),
    .accept_i   (accept),
    .flush_i    (Flush),
    .beat_i     (I),
    .count_o    (count),
    .complete_o (complete),
    .word_o     (word)
  );

  always_comb begin
    irout_d   = irout_q;
    irvalid_d = irvalid_q;
    overrun_d = overrun_q;
    if (Flush) begin
      irvalid_d = 1'b0;
      overrun_d = 1'b0;
    end else begin
      if (Write && !ready) overrun_d = 1'b1;
      if (complete) begin
        irout_d   = word;
        irvalid_d = 1'b1;
      end else if (Take) begin
        irvalid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      irout_q   <= '0;
      irvalid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      irout_q   <= irout_d;
      irvalid_q <= irvalid_d;
      overrun_q <= overrun_d;
    end
  end

  assign WriteReady = ready;
  assign IROut      = irout_q;
  assign IRValid    = irvalid_q;
  assign ByteCount  = count;
  assign Overrun    = overrun_q;

endmodule

// File: tb/tb_instruction_assembly_register.sv
// Randomized bench for instruction_assembly_register: three configurations
// share one stimulus stream and are compared against a word-level model.
module tb_instruction_assembly_register;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr = 1'b0, take = 1'b0, flush = 1'b0;
  logic [7:0] din = '0;

  logic        rdy0, val0, ovr0, rdy1, val1, ovr1, rdy2, val2, ovr2;
  logic [15:0] out0, out1;
  logic [11:0] out2;
  logic        cnt0, cnt1;
  logic [1:0]  cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instruction_assembly_register #(.BUS_W(8), .INSTR_BYTES(2), .HIGH_FIRST(1)) u_hi (
    .Clock(clk), .Reset(rst), .Write(wr), .I(din), .Take(take), .Flush(flush),
    .WriteReady(rdy0), .IROut(out0), .IRValid(val0), .ByteCount(cnt0), .Overrun(ovr0));

  instruction_assembly_register #(.BUS_W(8), .INSTR_BYTES(2), .HIGH_FIRST(0)) u_lo (
    .Clock(clk), .Reset(rst), .Write(wr), .I(din), .Take(take), .Flush(flush),
    .WriteReady(rdy1), .IROut(out1), .IRValid(val1), .ByteCount(cnt1), .Overrun(ovr1));

  instruction_assembly_register #(.BUS_W(4), .INSTR_BYTES(3), .HIGH_FIRST(1)) u_nib (
    .Clock(clk), .Reset(rst), .Write(wr), .I(din[3:0]), .Take(take), .Flush(flush),
    .WriteReady(rdy2), .IROut(out2), .IRValid(val2), .ByteCount(cnt2), .Overrun(ovr2));

  logic [31:0] g_out [3];
  logic [31:0] g_cnt [3];
  logic        g_val [3];
  logic        g_ovr [3];
  logic        g_rdy [3];

  assign g_out[0] = 32'(out0);
  assign g_out[1] = 32'(out1);
  assign g_out[2] = 32'(out2);
  assign g_cnt[0] = 32'(cnt0);
  assign g_cnt[1] = 32'(cnt1);
  assign g_cnt[2] = 32'(cnt2);
  assign g_val[0] = val0;
  assign g_val[1] = val1;
  assign g_val[2] = val2;
  assign g_ovr[0] = ovr0;
  assign g_ovr[1] = ovr1;
  assign g_ovr[2] = ovr2;
  assign g_rdy[0] = rdy0;
  assign g_rdy[1] = rdy1;
  assign g_rdy[2] = rdy2;

  // Model: per configuration, the beats gathered so far plus the held word.
  logic [7:0]  m_beats [3][8];
  int          m_cnt   [3];
  logic        m_val   [3];
  logic [31:0] m_out   [3];
  logic        m_ovr   [3];

  function automatic int nb(input int m);
    return (m == 2) ? 3 : 2;
  endfunction

  function automatic int bw(input int m);
    return (m == 2) ? 4 : 8;
  endfunction

  function automatic logic model_ready(input int m, input logic tk);
`ifdef IR_PREFETCH_EN
    return !m_val[m] || (m_cnt[m] != nb(m) - 1) || tk;
`else
    return !m_val[m];
`endif
  endfunction

  // First beat is most significant when HIGH_FIRST=1, least significant otherwise.
  function automatic logic [31:0] build_word(input int m);
    logic [31:0] w = '0;
    for (int k = 0; k < nb(m); k++) begin
      if (m == 1) w = w | (32'(m_beats[m][k]) << (k * bw(m)));
      else        w = (w << bw(m)) | 32'(m_beats[m][k]);
    end
    return w;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 3; m++) begin
      m_cnt[m] = 0;
      m_val[m] = 1'b0;
      m_out[m] = '0;
      m_ovr[m] = 1'b0;
    end
  endtask

  task automatic model_update(input logic w, input logic [7:0] d, input logic tk,
                              input logic fl);
    for (int m = 0; m < 3; m++) begin
      logic rdy;
      logic done;
      rdy  = model_ready(m, tk);
      done = 1'b0;
      if (fl) begin
        m_cnt[m] = 0;
        m_val[m] = 1'b0;
        m_ovr[m] = 1'b0;
      end else begin
        if (w && !rdy) m_ovr[m] = 1'b1;
        if (w && rdy) begin
          m_beats[m][m_cnt[m]] = d & ((m == 2) ? 8'h0F : 8'hFF);
          m_cnt[m] = m_cnt[m] + 1;
          if (m_cnt[m] == nb(m)) begin
            m_out[m] = build_word(m);
            m_val[m] = 1'b1;
            m_cnt[m] = 0;
            done     = 1'b1;
          end
        end
        if (!done && tk) m_val[m] = 1'b0;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_state();
    for (int m = 0; m < 3; m++) begin
      check($sformatf("irout%0d", m), g_out[m], m_out[m]);
      check($sformatf("irvalid%0d", m), 32'(g_val[m]), 32'(m_val[m]));
      check($sformatf("bytecount%0d", m), g_cnt[m], 32'(m_cnt[m]));
      check($sformatf("overrun%0d", m), 32'(g_ovr[m]), 32'(m_ovr[m]));
    end
  endtask

  task automatic step(input logic w, input logic [7:0] d, input logic tk, input logic fl);
    wr = w; din = d; take = tk; flush = fl;
    #1;
    for (int m = 0; m < 3; m++) begin
      check($sformatf("writeready%0d", m), 32'(g_rdy[m]), 32'(model_ready(m, tk)));
    end
    @(posedge clk);
    model_update(w, d, tk, fl);
    #1;
    check_state();
  endtask

  task automatic reset_pulse();
    wr = 1'b0; take = 1'b0; flush = 1'b0;
    #2 rst = 1'b1;
    model_reset();
    #1 check_state();
    rst = 1'b0;
  endtask

  logic [31:0] keep_word;

  initial begin
    model_reset();
    #3 check_state();
    #5 rst = 1'b0;

    step(1'b1, 8'h12, 1'b0, 1'b0);
    check("hi_notyet", 32'(val0), 32'd0);
    step(1'b1, 8'h34, 1'b0, 1'b0);
    check("hi_word", 32'(out0), 32'h1234);
    check("hi_valid", 32'(val0), 32'd1);
    check("lo_word", 32'(out1), 32'h3412);

`ifdef IR_PREFETCH_EN
    step(1'b1, 8'h56, 1'b0, 1'b0);
    check("pf_cnt", 32'(cnt0), 32'd1);
    check("pf_hold", 32'(out0), 32'h1234);
    step(1'b1, 8'h78, 1'b0, 1'b0);
    check("pf_refused_ovr", 32'(ovr0), 32'd1);
    check("pf_refused_cnt", 32'(cnt0), 32'd1);
    step(1'b1, 8'h78, 1'b1, 1'b0);
    check("pf_word", 32'(out0), 32'h5678);
    check("pf_valid", 32'(val0), 32'd1);
    keep_word = 32'h5678;
`else
    step(1'b1, 8'h9A, 1'b0, 1'b0);
    check("busy_ovr", 32'(ovr0), 32'd1);
    check("busy_hold", 32'(out0), 32'h1234);
    keep_word = 32'h1234;
`endif

    step(1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b1, 8'hCD, 1'b0, 1'b1);
    check("flush_cnt", 32'(cnt0), 32'd0);
    check("flush_valid", 32'(val0), 32'd0);
    check("flush_ovr", 32'(ovr0), 32'd0);
    check("flush_keep", 32'(out0), keep_word);

    step(1'b1, 8'hAB, 1'b0, 1'b0);
    check("pre_rst_cnt", 32'(cnt0), 32'd1);
    reset_pulse();
    check("rst_out", 32'(out0), 32'd0);
    check("rst_cnt", 32'(cnt0), 32'd0);
    step(1'b1, 8'h56, 1'b0, 1'b0);
    step(1'b1, 8'h78, 1'b0, 1'b0);
    check("rst_word", 32'(out0), 32'h5678);

    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("nib_cnt0", 32'(cnt2), 32'd0);
    step(1'b1, 8'h0A, 1'b0, 1'b0);
    check("nib_cnt1", 32'(cnt2), 32'd1);
    step(1'b1, 8'h0B, 1'b0, 1'b0);
    check("nib_cnt2", 32'(cnt2), 32'd2);
    step(1'b1, 8'h0C, 1'b0, 1'b0);
    check("nib_cnt3", 32'(cnt2), 32'd0);
    check("nib_word", 32'(out2), 32'h0ABC);
    check("nib_valid", 32'(val2), 32'd1);

    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        reset_pulse();
      end else begin
        step($urandom_range(0, 99) < 60, 8'($urandom), $urandom_range(0, 99) < 30,
             $urandom_range(0, 99) < 4);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
